// File: rtl/score_disp_fmt_pkg.sv
// -----------------------------------------------------------------------------
// score_disp_pkg
// Shared definitions for the score/time display formatter: FSM state
// encoding, saturation limits and decimal-point patterns.
// -----------------------------------------------------------------------------
package score_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONV_S  = 3'd1,
    ST_CONV_T  = 3'd2,
    ST_PUBLISH = 3'd3,
    ST_STROBE  = 3'd4
  } state_t;

  // Largest values the four score digits and two time digits can show
  localparam int SCORE_SAT = 9999;
  localparam int TIME_SAT  = 99;

  // Number of BCD digits produced by the shared converter (score field)
  localparam int SCORE_DIGITS = 4;

  // Decimal points are active-low, digit 0 in bit 0
  localparam logic [5:0] DP_ALL_OFF = 6'h3F;
  localparam logic [5:0] DP_SEP     = 6'b101111;

endpackage

// File: rtl/score_disp_fmt_if.sv
// -----------------------------------------------------------------------------
// score_disp_fmt_if
// Bundles the request side (upd/score/tsec) and the scanner side
// (busy/din/dpin/lk) of the display formatter.
//   master : producer of requests, consumer of display data (game logic / bench)
//   slave  : the formatter itself
// Ports: upd, score[SCORE_W], tsec[TIME_W], busy, din[24], dpin[6], lk
// -----------------------------------------------------------------------------
interface score_disp_fmt_if #(
  parameter int SCORE_W = 14,
  parameter int TIME_W  = 7
) ();

  logic               upd;
  logic [SCORE_W-1:0] score;
  logic [TIME_W-1:0]  tsec;
  logic               busy;
  logic [23:0]        din;
  logic [5:0]         dpin;
  logic               lk;

  modport master (
    output upd, score, tsec,
    input  busy, din, dpin, lk
  );

  modport slave (
    input  upd, score, tsec,
    output busy, din, dpin, lk
  );

endinterface

// File: rtl/score_disp_fmt_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 binary to BCD converter. A conversion of load_len
// bits takes exactly load_len cycles after the start edge. The value is
// left-aligned on load so shorter operands can reuse the same engine.
// done is high during the cycle whose closing edge performs the final shift;
// result is the BCD value that shift produces, so the caller captures it on
// that edge (and may restart the engine on the same edge).
// Ports: clk, rst (async, active-high), start, load_val[W], load_len,
//        done, result[4*ND]
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int W  = 14,
  parameter int ND = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W-1:0]           load_val,
  input  logic [$clog2(W+1)-1:0] load_len,
  output logic                   done,
  output logic [4*ND-1:0]        result
);

  localparam int LEN_W = $clog2(W + 1);

  logic [W-1:0]     bin_reg;
  logic [4*ND-1:0]  bcd_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             active_reg;
  logic [4*ND-1:0]  adj;
  logic             unused_adj_msb;

  // Add 3 to every digit that would overflow past 9 once doubled
  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                              (bcd_reg[gi*4 +: 4] + 4'd3) :
                              bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // The top adjusted bit only shifts out; inputs never exceed ND digits
  assign unused_adj_msb = adj[4*ND-1];
  assign result         = {adj[4*ND-2:0], bin_reg[W-1]};
  assign done           = active_reg && (cnt_reg == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      bin_reg    <= load_val << (W - int'(load_len));
      bcd_reg    <= '0;
      cnt_reg    <= load_len;
      active_reg <= (load_len != '0);
    end else if (active_reg) begin
      bin_reg <= bin_reg << 1;
      bcd_reg <= result;
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == LEN_W'(1)) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/score_disp_fmt.sv
// -----------------------------------------------------------------------------
// score_disp_fmt
// Converts the saturated game score and seconds remaining to six BCD digits
// for the multiplexed display scanner, then publishes din/dpin and issues a
// latch strobe lk of LK_W cycles starting one cycle after the data changes.
// Requests arriving while busy are remembered (one deep) and served with
// freshly sampled inputs.
// Ports: clk, rst (async, active-high), bus (score_disp_fmt_if.slave:
//        upd, score, tsec in; busy, din, dpin, lk out)
// Build option: define SCORE_DISP_DP_EN to light the decimal point on
//        digit 4 (seconds/score separator); otherwise all points stay off.
// -----------------------------------------------------------------------------
module score_disp_fmt
  import score_disp_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int TIME_W  = 7,
  parameter int LK_W    = 4
) (
  input logic              clk,
  input logic              rst,
  score_disp_fmt_if.slave  bus
);

  localparam int LEN_W = $clog2(SCORE_W + 1);
  localparam int LKC_W = $clog2(LK_W + 1);

  state_t                  state_reg, state_next;
  logic                    pending_reg, pending_next;
  logic [TIME_W-1:0]       tsec_cap_reg;
  logic [4*SCORE_DIGITS-1:0] score_bcd_reg;
  logic [7:0]              time_bcd_reg;
  logic [23:0]             din_reg;
  logic [5:0]              dpin_reg;
  logic                    lk_reg, lk_next;
  logic [LKC_W-1:0]        lk_cnt_reg, lk_cnt_next;

  logic [SCORE_W-1:0]      score_sat;
  logic [TIME_W-1:0]       tsec_sat;
  logic                    accept, cap_score, cap_time, publish;
  logic                    eng_start, eng_done;
  logic [SCORE_W-1:0]      eng_val;
  logic [LEN_W-1:0]        eng_len;
  logic [4*SCORE_DIGITS-1:0] eng_result;

  assign score_sat = (bus.score > SCORE_W'(SCORE_SAT)) ? SCORE_W'(SCORE_SAT) : bus.score;
  assign tsec_sat  = (bus.tsec  > TIME_W'(TIME_SAT))   ? TIME_W'(TIME_SAT)   : bus.tsec;

  // One converter serves both fields: score first, then the seconds value
  bin2bcd_seq #(.W(SCORE_W), .ND(SCORE_DIGITS)) u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .load_val (eng_val),
    .load_len (eng_len),
    .done     (eng_done),
    .result   (eng_result)
  );

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg | bus.upd;
    lk_next      = lk_reg;
    lk_cnt_next  = lk_cnt_reg;
    accept       = 1'b0;
    cap_score    = 1'b0;
    cap_time     = 1'b0;
    publish      = 1'b0;
    eng_start    = 1'b0;
    eng_val      = score_sat;
    eng_len      = LEN_W'(SCORE_W);
    case (state_reg)
      ST_IDLE: begin
        if (bus.upd || pending_reg) begin
          accept       = 1'b1;
          eng_start    = 1'b1;
          pending_next = 1'b0;
          state_next   = ST_CONV_S;
        end
      end
      ST_CONV_S: begin
        // Final score shift and seconds load share the same edge
        if (eng_done) begin
          cap_score  = 1'b1;
          eng_start  = 1'b1;
          eng_val    = SCORE_W'(tsec_cap_reg);
          eng_len    = LEN_W'(TIME_W);
          state_next = ST_CONV_T;
        end
      end
      ST_CONV_T: begin
        if (eng_done) begin
          cap_time   = 1'b1;
          state_next = ST_PUBLISH;
        end
      end
      ST_PUBLISH: begin
        publish     = 1'b1;
        lk_cnt_next = '0;
        state_next  = ST_STROBE;
      end
      ST_STROBE: begin
        // First STROBE edge raises lk, so data leads the strobe by a cycle
        if (lk_cnt_reg == LKC_W'(LK_W)) begin
          lk_next    = 1'b0;
          state_next = ST_IDLE;
        end else begin
          lk_next     = 1'b1;
          lk_cnt_next = lk_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= 1'b0;
      tsec_cap_reg  <= '0;
      score_bcd_reg <= '0;
      time_bcd_reg  <= '0;
      din_reg       <= 24'h000000;
      dpin_reg      <= DP_ALL_OFF;
      lk_reg        <= 1'b0;
      lk_cnt_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      lk_reg      <= lk_next;
      lk_cnt_reg  <= lk_cnt_next;
      if (accept)    tsec_cap_reg  <= tsec_sat;
      if (cap_score) score_bcd_reg <= eng_result;
      if (cap_time)  time_bcd_reg  <= eng_result[7:0];
      if (publish) begin
        din_reg <= {time_bcd_reg, score_bcd_reg};
`ifdef SCORE_DISP_DP_EN
        dpin_reg <= DP_SEP;
`else
        dpin_reg <= DP_ALL_OFF;
`endif
      end
    end
  end

  assign bus.busy = (state_reg != ST_IDLE);
  assign bus.din  = din_reg;
  assign bus.dpin = dpin_reg;
  assign bus.lk   = lk_reg;

endmodule

// File: tb/tb_score_disp_fmt.sv
// -----------------------------------------------------------------------------
// tb_score_disp_fmt
// Scoreboard bench for score_disp_fmt: each accepted request pushes its
// expected din/dpin; a monitor pops and compares on every rising lk.
// -----------------------------------------------------------------------------
module tb_score_disp_fmt;
  import score_disp_pkg::*;

  localparam int SCORE_W = 14;
  localparam int TIME_W  = 7;
  localparam int LK_W    = 4;

`ifdef SCORE_DISP_DP_EN
  localparam logic [5:0] EXP_DP = 6'b101111;
`else
  localparam logic [5:0] EXP_DP = 6'h3F;
`endif

  typedef struct {
    logic [23:0] din;
    logic [5:0]  dpin;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_disp_fmt_if #(.SCORE_W(SCORE_W), .TIME_W(TIME_W)) bus ();

  score_disp_fmt #(.SCORE_W(SCORE_W), .TIME_W(TIME_W), .LK_W(LK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vecs     = 0;
  int   errs     = 0;
  int   cyc      = 0;
  int   lk_count = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_din(input int s_in, input int t_in);
    int s, t;
    s = (s_in > 9999) ? 9999 : s_in;
    t = (t_in > 99) ? 99 : t_in;
    return {4'(t / 10), 4'(t % 10), 4'(s / 1000), 4'((s / 100) % 10),
            4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic push_exp(input int s, input int t);
    exp_t e;
    e.din  = exp_din(s, t);
    e.dpin = EXP_DP;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input int s, input int t);
    bus.score = SCORE_W'(s);
    bus.tsec  = TIME_W'(t);
  endtask

  task automatic pulse_upd();
    @(posedge clk); #1 bus.upd = 1'b1;
    @(posedge clk); #1 bus.upd = 1'b0;
  endtask

  // Idle means busy low for three consecutive cycles (covers pending gaps)
  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 3; i++) begin
      @(negedge clk);
      if (!bus.busy) quiet++;
      else quiet = 0;
    end
    chk("idle_timeout", 32'(quiet >= 3), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard monitor: compare on lk rise, check strobe width on lk fall
  initial begin
    exp_t e;
    logic lk_prev = 1'b0;
    int   lk_width = 0;
    forever begin
      @(negedge clk);
      if (bus.lk && !lk_prev) begin
        lk_count++;
        lk_width = 0;
        chk("lk_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("din", 32'(bus.din), 32'(e.din));
          chk("dpin", 32'(bus.dpin), 32'(e.dpin));
        end
        $display("publish cycle %0d din=%h dpin=%b", cyc, bus.din, bus.dpin);
      end
      if (bus.lk) lk_width++;
      if (!bus.lk && lk_prev) chk("lk_width", 32'(lk_width), LK_W);
      lk_prev = bus.lk;
    end
  end

  initial begin
    int s_tab[6] = '{12000, 0, 9999, 10000, 3, 1};
    int t_tab[6] = '{120, 0, 99, 5, 100, 2};
    int s, t, lk_base;

    bus.upd = 1'b0;
    set_in(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", 32'(bus.din), 32'h000000);
    chk("rst_dpin", 32'(bus.dpin), 32'h3F);
    chk("rst_lk", 32'(bus.lk), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;

    // Latency check: upd sampled at edge 0, din at 22, lk 23..26, idle at 27
    set_in(1234, 56);
    push_exp(1234, 56);
    pulse_upd();
    repeat (21) @(posedge clk);
    @(negedge clk);
    chk("din_hold_e21", 32'(bus.din), 32'h000000);
    chk("busy_e21", 32'(bus.busy), 1);
    @(negedge clk);
    chk("din_e22", 32'(bus.din), 32'h561234);
    chk("dpin_e22", 32'(bus.dpin), 32'(EXP_DP));
    chk("lk_e22", 32'(bus.lk), 0);
    @(negedge clk);
    chk("lk_e23", 32'(bus.lk), 1);
    repeat (3) @(negedge clk);
    chk("lk_e26", 32'(bus.lk), 1);
    chk("busy_e26", 32'(bus.busy), 1);
    @(negedge clk);
    chk("lk_e27", 32'(bus.lk), 0);
    chk("busy_e27", 32'(bus.busy), 0);
    wait_idle();

    // Directed saturation / boundary table, then a few random requests
    for (int i = 0; i < 6; i++) begin
      set_in(s_tab[i], t_tab[i]);
      push_exp(s_tab[i], t_tab[i]);
      pulse_upd();
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      s = int'($urandom_range(0, 16383));
      t = int'($urandom_range(0, 127));
      set_in(s, t);
      push_exp(s, t);
      pulse_upd();
      wait_idle();
    end

    // Request while busy: served afterwards with re-sampled inputs
    set_in(100, 30);
    push_exp(100, 30);
    pulse_upd();
    repeat (3) @(posedge clk);
    set_in(42, 7);
    push_exp(42, 7);
    pulse_upd();
    wait_idle();
    chk("pending_din", 32'(bus.din), 32'h070042);

    // Three requests while busy collapse into one extra run
    lk_base = lk_count;
    set_in(500, 45);
    push_exp(500, 45);
    pulse_upd();
    set_in(777, 33);
    push_exp(777, 33);
    repeat (3) begin
      pulse_upd();
      repeat (2) @(posedge clk);
    end
    wait_idle();
    chk("collapse_lk_count", 32'(lk_count - lk_base), 2);

    // Reset in the middle of the score conversion
    lk_base = lk_count;
    set_in(1234, 56);
    pulse_upd();
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_din", 32'(bus.din), 32'h000000);
    chk("midrst_dpin", 32'(bus.dpin), 32'h3F);
    chk("midrst_lk", 32'(bus.lk), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_lk", 32'(lk_count - lk_base), 0);

    set_in(4321, 12);
    push_exp(4321, 12);
    pulse_upd();
    wait_idle();
    chk("post_rst_din", 32'(bus.din), 32'h124321);

    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
